// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the 7-segment scan driver and its BCD converter:
//   converter FSM state codes, display geometry, segment constants and the
//   4-bit to 7-segment decode function.
//   Segment bit order is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  // Converter FSM state codes
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } bcd_state_t;

  // Converter geometry: 8 binary bits become 3 BCD nibbles
  localparam int BIN_W        = 8;
  localparam int BCD_W        = 12;
  localparam int SR_W         = BCD_W + BIN_W;
  localparam int DABBLE_ITERS = BIN_W;
  localparam int NUM_DIGITS   = 4;

  // Segment constants
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // 4-bit value to segment pattern; codes 10..15 never occur for valid BCD
  // and are shown dark rather than as hex glyphs.
  function automatic logic [6:0] seg7_decode(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential double-dabble converter, one iteration per clock.
//   Ports:
//     clk    - clock
//     rst_i  - synchronous active-high reset
//     start  - request a conversion; accepted only while idle
//     din    - 8-bit binary value, loaded on an accepted start
//     bcd    - {hundreds, tens, ones}; final while done is high
//     done   - high for the single cycle the result is complete
//     busy   - registered, high from the cycle after start until the
//              cycle after done
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 start,
  input  logic [BIN_W-1:0]     din,
  output logic [BCD_W-1:0]     bcd,
  output logic                 done,
  output logic                 busy
);

  bcd_state_t       state_reg, state_next;
  logic [SR_W-1:0]  sr_reg, sr_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic             busy_reg;

  // One double-dabble step: correct every BCD nibble that would overflow
  // past 9 when doubled, then shift the whole register left by one.
  logic [3:0]       nib_adj [3];
  logic [SR_W-1:0]  sr_step;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib          = sr_reg[BIN_W + 4*gi +: 4];
      assign nib_adj[gi]  = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
  endgenerate

  assign sr_step = {nib_adj[2][2:0], nib_adj[1], nib_adj[0], sr_reg[BIN_W-1:0], 1'b0};

  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          sr_next    = {{BCD_W{1'b0}}, din};
          cnt_next   = 4'd0;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_next  = sr_step;
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'(DABBLE_ITERS - 1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      sr_reg    <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sr_reg    <= sr_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= (state_next != ST_IDLE);
    end
  end

  assign bcd  = sr_reg[SR_W-1:BIN_W];
  assign done = (state_reg == ST_DONE);
  assign busy = busy_reg;

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Drives a 4-digit multiplexed common-anode 7-segment display.
//   Digit 3 shows the state code (0..4 as digits, 5..7 as a dash), digits
//   2..0 show dind_i in decimal. The value is converted to BCD only when
//   the inputs change; the display keeps showing the previously committed
//   value until a conversion completes.
//   Parameters:
//     SCAN_DIV - clock cycles per digit slot (1..255)
//     BLANK_LZ - blank leading zeros on hundreds and tens digits
//   Ports:
//     clc_i    - clock
//     rst_i    - synchronous active-high reset
//     dind_i   - binary value to display
//     state_i  - 3-bit state code
//     bcd_out  - committed BCD {hundreds, tens, ones}
//     busy_out - conversion in progress
//     seg_out  - segments {g,f,e,d,c,b,a}, active-high, registered
//     an_out   - digit anodes, active-low one-hot, registered
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 1,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clc_i,
  input  logic        rst_i,
  input  logic [7:0]  dind_i,
  input  logic [2:0]  state_i,
  output logic [11:0] bcd_out,
  output logic        busy_out,
  output logic [6:0]  seg_out,
  output logic [3:0]  an_out
);

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

  // Change detection and committed display registers
  logic [7:0]  dind_cap_reg;
  logic [2:0]  state_cap_reg;
  logic        valid_reg;
  logic [11:0] bcd_reg;
  logic [2:0]  disp_state_reg;

  // Scan and output registers
  logic [7:0]  div_reg;
  logic [1:0]  idx_reg;
  logic [6:0]  seg_reg;
  logic [3:0]  an_reg;

  logic        conv_start;
  logic        conv_busy;
  logic        conv_done;
  logic [11:0] conv_bcd;

  // A conversion is requested whenever the inputs differ from what was last
  // captured, and unconditionally until the first result after reset has been
  // committed. The converter only accepts it while idle, so anything that
  // changes mid-conversion is caught by this compare once it returns to idle.
  assign conv_start = !conv_busy &&
                      ((dind_i != dind_cap_reg) ||
                       (state_i != state_cap_reg) ||
                       !valid_reg);

  bin2bcd_seq u_bin2bcd (
    .clk   (clc_i),
    .rst_i (rst_i),
    .start (conv_start),
    .din   (dind_i),
    .bcd   (conv_bcd),
    .done  (conv_done),
    .busy  (conv_busy)
  );

  always_ff @(posedge clc_i) begin
    if (rst_i) begin
      dind_cap_reg   <= '0;
      state_cap_reg  <= '0;
      valid_reg      <= 1'b0;
      bcd_reg        <= '0;
      disp_state_reg <= '0;
    end else begin
      if (conv_start) begin
        dind_cap_reg  <= dind_i;
        state_cap_reg <= state_i;
      end
      if (conv_done) begin
        bcd_reg        <= conv_bcd;
        disp_state_reg <= state_cap_reg;
        valid_reg      <= 1'b1;
      end
    end
  end

  // Per-digit segment patterns from the committed registers
  logic [2:0] blank_lz;
  logic [6:0] digit_seg [NUM_DIGITS];

  assign blank_lz[0] = 1'b0;
  assign blank_lz[1] = BLANK_LZ && (bcd_reg[11:8] == 4'd0) && (bcd_reg[7:4] == 4'd0);
  assign blank_lz[2] = BLANK_LZ && (bcd_reg[11:8] == 4'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_digit
      assign digit_seg[gi] = blank_lz[gi] ? SEG_BLANK : seg7_decode(bcd_reg[4*gi +: 4]);
    end
  endgenerate

  assign digit_seg[3] = (disp_state_reg <= 3'd4) ? seg7_decode({1'b0, disp_state_reg})
                                                 : SEG_DASH;

  // Scan counter runs freely, independent of converter activity
  always_ff @(posedge clc_i) begin
    if (rst_i) begin
      div_reg <= '0;
      idx_reg <= '0;
      seg_reg <= SEG_BLANK;
      an_reg  <= 4'b1111;
    end else begin
      seg_reg <= digit_seg[idx_reg];
      an_reg  <= ~(4'b0001 << idx_reg);
      if (div_reg == DIV_LAST) begin
        div_reg <= '0;
        idx_reg <= idx_reg + 2'd1;
      end else begin
        div_reg <= div_reg + 8'd1;
      end
    end
  end

  assign bcd_out  = bcd_reg;
  assign busy_out = conv_busy;
  assign seg_out  = seg_reg;
  assign an_out   = an_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Three driver instances share one stimulus stream:
//     u0: SCAN_DIV=1, BLANK_LZ=1   u1: SCAN_DIV=1, BLANK_LZ=0
//     u2: SCAN_DIV=2, BLANK_LZ=1
//   A behavioural reference model runs alongside and every output of every
//   instance is compared against it on each falling edge. Directed vectors
//   and hand-written sequences check the spec's concrete values.
module tb_seg7_scan_driver;

  localparam int SD  [3] = '{1, 1, 2};
  localparam bit BLK [3] = '{1'b1, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  dind = 8'd0;
  logic [2:0]  st = 3'd0;

  logic [11:0] bcd_w  [3];
  logic        busy_w [3];
  logic [6:0]  seg_w  [3];
  logic [3:0]  an_w   [3];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      seg7_scan_driver #(
        .SCAN_DIV (SD[gi]),
        .BLANK_LZ (BLK[gi])
      ) u_dut (
        .clc_i    (clk),
        .rst_i    (rst),
        .dind_i   (dind),
        .state_i  (st),
        .bcd_out  (bcd_w[gi]),
        .busy_out (busy_w[gi]),
        .seg_out  (seg_w[gi]),
        .an_out   (an_w[gi])
      );
    end
  endgenerate

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [10];
  initial seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input int idx, input logic [11:0] b,
                                         input logic [2:0] s, input bit blk);
    int h, t, o;
    h = int'(b[11:8]);
    t = int'(b[7:4]);
    o = int'(b[3:0]);
    case (idx)
      0:       return seg_tab[o];
      1:       return (blk && h == 0 && t == 0) ? 7'h00 : seg_tab[t];
      2:       return (blk && h == 0) ? 7'h00 : seg_tab[h];
      default: return (s <= 3'd4) ? seg_tab[int'(s)] : 7'h40;
    endcase
  endfunction

  // Conversion is modelled as: accepted when idle and the inputs differ from
  // the last capture (or nothing committed yet); result visible 9 edges later.
  int          m_remain = 0;
  logic [7:0]  m_cap_d  = '0;
  logic [2:0]  m_cap_s  = '0;
  bit          m_valid  = 0;
  logic [11:0] m_pend   = '0;
  logic [11:0] m_bcd    = '0;
  logic [2:0]  m_disp   = '0;
  int          m_slot_cnt [3];
  int          m_idx      [3];
  logic [6:0]  m_seg      [3];
  logic [3:0]  m_an       [3];
  bit          model_ok = 0;

  always @(posedge clk) begin
    model_ok <= 1'b1;
    if (rst) begin
      m_remain <= 0;
      m_cap_d  <= '0;
      m_cap_s  <= '0;
      m_valid  <= 0;
      m_bcd    <= '0;
      m_disp   <= '0;
      for (int k = 0; k < 3; k++) begin
        m_slot_cnt[k] <= 0;
        m_idx[k]      <= 0;
        m_seg[k]      <= 7'h00;
        m_an[k]       <= 4'b1111;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_an[k]  <= ~(4'b0001 << m_idx[k]);
        m_seg[k] <= exp_seg(m_idx[k], m_bcd, m_disp, BLK[k]);
        if (m_slot_cnt[k] + 1 >= SD[k]) begin
          m_slot_cnt[k] <= 0;
          m_idx[k]      <= (m_idx[k] + 1) % 4;
        end else begin
          m_slot_cnt[k] <= m_slot_cnt[k] + 1;
        end
      end
      if (m_remain == 0) begin
        if (dind != m_cap_d || st != m_cap_s || !m_valid) begin
          m_cap_d  <= dind;
          m_cap_s  <= st;
          m_pend   <= ref_bcd(int'(dind));
          m_remain <= 9;
        end
      end else begin
        m_remain <= m_remain - 1;
        if (m_remain == 1) begin
          m_bcd   <= m_pend;
          m_disp  <= m_cap_s;
          m_valid <= 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model_bcd_u%0d", k),  32'(bcd_w[k]),  32'(m_bcd));
        chk($sformatf("model_busy_u%0d", k), 32'(busy_w[k]), 32'(m_remain != 0));
        chk($sformatf("model_seg_u%0d", k),  32'(seg_w[k]),  32'(m_seg[k]));
        chk($sformatf("model_an_u%0d", k),   32'(an_w[k]),   32'(m_an[k]));
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy_w[0] && n < 30) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, 32'(busy_w[0]), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  d;
    logic [2:0]  s;
    logic [11:0] bcd;
    logic [6:0]  e0, e1, e2, e3;
    logic [6:0]  n1, n2;
  } vec_t;

  vec_t vecs [8];

  initial begin
    // watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] an_seq2 [8];
    logic [6:0] got0 [4];
    logic [6:0] got1 [4];
    int n, idx;

    vecs[0] = '{8'd0,   3'd0, 12'h000, 7'h3F, 7'h00, 7'h00, 7'h3F, 7'h3F, 7'h3F};
    vecs[1] = '{8'd255, 3'd4, 12'h255, 7'h6D, 7'h6D, 7'h5B, 7'h66, 7'h6D, 7'h5B};
    vecs[2] = '{8'd7,   3'd0, 12'h007, 7'h07, 7'h00, 7'h00, 7'h3F, 7'h3F, 7'h3F};
    vecs[3] = '{8'd12,  3'd6, 12'h012, 7'h5B, 7'h06, 7'h00, 7'h40, 7'h06, 7'h3F};
    vecs[4] = '{8'd100, 3'd2, 12'h100, 7'h3F, 7'h3F, 7'h06, 7'h5B, 7'h3F, 7'h06};
    vecs[5] = '{8'd45,  3'd7, 12'h045, 7'h6D, 7'h66, 7'h00, 7'h40, 7'h66, 7'h3F};
    vecs[6] = '{8'd9,   3'd3, 12'h009, 7'h6F, 7'h00, 7'h00, 7'h4F, 7'h3F, 7'h3F};
    vecs[7] = '{8'd230, 3'd5, 12'h230, 7'h3F, 7'h4F, 7'h5B, 7'h40, 7'h4F, 7'h5B};
    an_seq2 = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7};

    // --- reset state and first edge after release ---
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_an",   32'(an_w[0]),   32'hF);
    chk("rst_seg",  32'(seg_w[0]),  32'h00);
    chk("rst_bcd",  32'(bcd_w[0]),  32'h000);
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
    rst = 1'b0;
    tick();
    chk("first_an",   32'(an_w[0]),   32'hE);
    chk("first_seg",  32'(seg_w[0]),  32'h3F);
    chk("first_busy", 32'(busy_w[0]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("div2_an_%0d", i), 32'(an_w[2]), 32'(an_seq2[i]));
      if (i < 7) tick();
    end
    wait_idle("startup");
    chk("startup_bcd", 32'(bcd_w[0]), 32'h000);
    $display("seq startup: bcd=%03h", bcd_w[0]);

    // --- 255/4: busy length and result ---
    dind = 8'd255; st = 3'd4;
    tick();
    n = 0;
    while (busy_w[0] && n < 20) begin
      n++;
      tick();
    end
    chk("busy_len", 32'(n), 32'd9);
    chk("bcd_255",  32'(bcd_w[0]), 32'h255);
    $display("seq 255: busy cycles=%0d bcd=%03h", n, bcd_w[0]);

    // --- 12 then 34 applied at E3 ---
    dind = 8'd12; st = 3'd1;
    tick();                 // E0
    repeat (3) tick();      // E3
    dind = 8'd34;
    repeat (6) tick();      // E9
    chk("chg_bcd_e9",  32'(bcd_w[0]), 32'h012);
    chk("chg_busy_e9", 32'(busy_w[0]), 32'd0);
    tick();                 // E10: restart
    chk("chg_busy_e10", 32'(busy_w[0]), 32'd1);
    chk("chg_bcd_e10",  32'(bcd_w[0]),  32'h012);
    repeat (9) tick();      // E19
    chk("chg_bcd_e19", 32'(bcd_w[0]), 32'h034);
    $display("seq 12->34: bcd=%03h", bcd_w[0]);

    // --- reset at E5 aborts, then restarts ---
    dind = 8'd99; st = 3'd1;
    tick();                 // E0
    repeat (4) tick();      // E4
    rst = 1'b1;
    tick();                 // E5 under reset
    chk("abort_an",   32'(an_w[0]),   32'hF);
    chk("abort_seg",  32'(seg_w[0]),  32'h00);
    chk("abort_bcd",  32'(bcd_w[0]),  32'h000);
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    rst = 1'b0;
    tick();
    chk("abort_restart_busy", 32'(busy_w[0]), 32'd1);
    chk("abort_restart_an",   32'(an_w[0]),   32'hE);
    wait_idle("abort");
    chk("abort_bcd_final", 32'(bcd_w[0]), 32'h099);
    $display("seq reset-abort: bcd=%03h", bcd_w[0]);

    // --- table-driven vectors ---
    for (int v = 0; v < 8; v++) begin
      dind = vecs[v].d; st = vecs[v].s;
      tick();
      wait_idle($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_bcd", v), 32'(bcd_w[0]), 32'(vecs[v].bcd));
      for (int c = 0; c < 4; c++) begin
        tick();
        idx = 0;
        for (int b = 0; b < 4; b++) if (!an_w[0][b]) idx = b;
        got0[idx] = seg_w[0];
        got1[idx] = seg_w[1];
      end
      chk($sformatf("vec%0d_d0", v),    32'(got0[0]), 32'(vecs[v].e0));
      chk($sformatf("vec%0d_d1", v),    32'(got0[1]), 32'(vecs[v].e1));
      chk($sformatf("vec%0d_d2", v),    32'(got0[2]), 32'(vecs[v].e2));
      chk($sformatf("vec%0d_d3", v),    32'(got0[3]), 32'(vecs[v].e3));
      chk($sformatf("vec%0d_nb_d1", v), 32'(got1[1]), 32'(vecs[v].n1));
      chk($sformatf("vec%0d_nb_d2", v), 32'(got1[2]), 32'(vecs[v].n2));
      $display("vec %0d: dind=%0d state=%0d bcd=%03h segs=%02h %02h %02h %02h",
               v, vecs[v].d, vecs[v].s, bcd_w[0], got0[3], got0[2], got0[1], got0[0]);
    end

    // --- randomized traffic against the model ---
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        n = int'($urandom_range(1, 3));
        repeat (n) tick();
        rst = 1'b0;
        $display("rnd %0d: reset for %0d cycles", t, n);
      end else begin
        if ($urandom_range(0, 3) != 0) begin
          dind = 8'($urandom_range(0, 255));
          st   = 3'($urandom_range(0, 7));
        end
        n = int'($urandom_range(1, 25));
        repeat (n) tick();
        $display("rnd %0d: dind=%0d state=%0d hold=%0d bcd=%03h", t, dind, st, n, bcd_w[0]);
      end
    end
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Display back end for the counter FSM. Takes the 8-bit indication value and the 3-bit state code and drives a 4-digit multiplexed common-anode 7-segment display. Digit 3 shows the state code; digits 2..0 show the value in decimal. A sequential double-dabble converter turns the value into BCD only when the inputs change, and a scan counter refreshes one digit per slot.

## Interface
- `SCAN_DIV`, default 1: clock cycles per digit slot; allowed range 1..255.
- `BLANK_LZ`, default 1: when 1, blank leading zeros on digits 2 and 1.
- `clc_i`, input, 1: system clock (same domain as the counter FSM).
- `rst_i`, input, 1: reset, synchronous and active-high.
- `dind_i`, input, 8: binary value to display, driven by `dind_out` of the counter FSM.
- `state_i`, input, 3: state code, driven by `debug_out` of the counter FSM.
- `bcd_out`, output, 12: committed BCD value {hundreds, tens, ones}.
- `busy_out`, output, 1: high while a conversion is in progress.
- `seg_out`, output, 7: segments {g,f,e,d,c,b,a}, active-high.
- `an_out`, output, 4: digit anodes, active-low, one-hot; bit 0 is the ones digit.

## Operation
- Converter FSM has three states: IDLE, SHIFT, DONE.
- IDLE: a conversion starts when any of the following holds:
  - `dind_i` differs from the last captured value,
  - `state_i` differs from the last captured state,
  - the post-reset `valid` flag is still 0.
- On start:
  - capture `dind_i` and `state_i`,
  - load the shift register with {12'b0, `dind_i`} and clear the iteration counter,
  - go to SHIFT.
- SHIFT: each cycle, add 3 to every BCD nibble ≥ 5, then shift left by 1. After 8 iterations go to DONE.
- DONE: commit the BCD nibbles to `bcd_out` and the captured state to the display state register, set `valid`, return to IDLE.
- Input changes during SHIFT or DONE are ignored. They are picked up by the change compare on the next IDLE cycle.
- Arithmetic: 20-bit shift register; every nibble result stays ≤ 9; maximum value 255 gives 0x255. No overflow is possible.
- Digit mapping:
  - digit 0 = ones, digit 1 = tens, digit 2 = hundreds: decoded 0–9.
  - digit 3 = state: values 0–4 decoded as digits; values 5–7 show dash (7'h40).
- Blanking, when `BLANK_LZ`=1:
  - hundreds is blank (7'h00) if 0,
  - tens is blank if hundreds = 0 and tens = 0,
  - ones and the state digit are never blank.
- Scan:
  - divider counts 0..`SCAN_DIV`−1,
  - on wrap, the digit index advances 0→1→2→3→0,
  - `an_out` = ~(1 << index),
  - `seg_out` = decode of the indexed digit.
- `an_out` and `seg_out` are registered from the current index and the committed registers.

## Timing
- Reset values:
  - FSM in IDLE, `valid` = 0, captured registers = 0,
  - `bcd_out` = 12'h000, `busy_out` = 0,
  - `seg_out` = 7'h00, `an_out` = 4'b1111,
  - digit index and divider = 0.
- First edge after reset release: `an_out` = 4'b1110, `seg_out` = 7'h3F (ones digit 0).
- The same cycle starts the forced conversion.
- Latency: edge E0 samples the change in IDLE. Shifts happen at E1..E8. E9 (DONE) updates `bcd_out`. The display shows the new value from the first `seg_out` register update after E9.
- `busy_out` is registered: high after E0, low after E9. A new start can occur at E10 at the earliest.
- A reset asserted mid-conversion aborts the conversion. All registers return to their reset values on that edge. Because `valid` is cleared, a fresh conversion starts when reset is released.
- Digit slot length is exactly `SCAN_DIV` cycles. A full frame is 4·`SCAN_DIV` cycles.
- Scan continues unaffected by conversion activity and shows the old committed value until DONE.

## Structure
- Shared package `seg7_pkg` holds:
  - FSM state localparams,
  - segment constants (`SEG_BLANK` = 7'h00, `SEG_DASH` = 7'h40),
  - the `seg7_decode` function (4-bit to 7-segment; codes 10–15 decode to `SEG_BLANK`).
- Sub-module `bin2bcd_seq`:
  - contains the IDLE/SHIFT/DONE FSM,
  - ports: start, din[7:0], bcd[11:0], done, busy.
- The top level holds the change detection, blanking, scan counter and output registers.

## Test plan
- Reset, then hold `dind_i`=0 and `state_i`=0 → after reset release: one conversion; `bcd_out`=0x000; digit 0 shows 7'h3F, digits 1 and 2 blank, digit 3 shows 7'h3F.
- `dind_i`=255, `state_i`=4 → `busy_out` high for 9 cycles; `bcd_out`=0x255 at E9; scan shows 7'h6D, 7'h6D, 7'h5B, 7'h66.
- `BLANK_LZ`=1, `dind_i`=7 → digits 2 and 1 show 7'h00, digit 0 shows 7'h07. With `BLANK_LZ`=0, digits 2 and 1 show 7'h3F.
- `dind_i`=12, then 34 applied at E3 of that conversion → `bcd_out`=0x012 at E9, then 0x034 ten edges later. No intermediate value appears.
- `state_i`=6 → digit 3 shows 7'h40. Assert reset at E5 of a conversion → all outputs return to reset values; the conversion restarts after release.
- `SCAN_DIV`=2 → `an_out` sequence 1110, 1110, 1101, 1101, 1011, 1011, 0111, 0111, then repeats.
